// File: rtl/lm75a_temp_decoder_if.sv
// LM75A decoder bus: raw register word in, decoded temperature and status out.
interface lm75a_temp_decoder_if;
  logic [15:0] data_in;
  logic        data_valid;
  logic        busy;
  logic        out_valid;
  logic [10:0] temp_raw;
  logic        sign;
  logic [3:0]  bcd_hund;
  logic [3:0]  bcd_tens;
  logic [3:0]  bcd_ones;
  logic [3:0]  bcd_tenth;
  logic        os_alarm;
  logic        overrun;

  modport master (
    output data_in, data_valid,
    input  busy, out_valid, temp_raw, sign,
    input  bcd_hund, bcd_tens, bcd_ones, bcd_tenth,
    input  os_alarm, overrun
  );

  modport slave (
    input  data_in, data_valid,
    output busy, out_valid, temp_raw, sign,
    output bcd_hund, bcd_tens, bcd_ones, bcd_tenth,
    output os_alarm, overrun
  );
endinterface

// File: rtl/lm75a_temp_decoder.sv
// LM75A temperature word to sign + BCD digits, with hysteretic over-temp alarm.
module lm75a_temp_decoder #(
  parameter logic signed [7:0] T_OS   = 8'sd80,
  parameter logic signed [7:0] T_HYST = 8'sd75
) (
  input logic clk,
  input logic rst,
  lm75a_temp_decoder_if.slave bus
);
  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  localparam logic signed [11:0] OS_RAW = {T_OS[7], T_OS, 3'b000};
  localparam logic signed [11:0] HY_RAW = {T_HYST[7], T_HYST, 3'b000};

  state_t       state;
  state_t       state_nxt;
  logic [19:0]  sh;
  logic [2:0]   cnt;
  logic [10:0]  raw_q;
  logic [2:0]   frac_q;
  logic [10:0]  slot;
  logic         slot_full;
  logic         have_next;
  logic [10:0]  next_raw;
  logic [10:0]  mag;
  logic signed [11:0] raw_s;
  logic         unused;

  assign unused = ^bus.data_in[4:0];

  function automatic logic [19:0] dabble(input logic [19:0] s);
    logic [19:0] t;
    t = s;
    for (int i = 0; i < 3; i++) begin
      if (t[8+4*i +: 4] >= 4'd5)
        t[8+4*i +: 4] = t[8+4*i +: 4] + 4'd3;
    end
    return {t[18:0], 1'b0};
  endfunction

  // eighths -> tenths, floor(f*1.25): skip 4 once f reaches 4
  function automatic logic [3:0] tenth_of(input logic [2:0] f);
    return {1'b0, f} + {3'b000, f[2]};
  endfunction

  always_comb begin
    have_next = bus.data_valid | slot_full;
    next_raw  = bus.data_valid ? bus.data_in[15:5] : slot;
    mag       = next_raw[10] ? (~next_raw + 11'd1) : next_raw;
    raw_s     = {raw_q[10], raw_q};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (bus.data_valid) state_nxt = CONV;
      CONV:    if (cnt == 3'd7) state_nxt = DONE;
      DONE:    state_nxt = have_next ? CONV : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.busy = (state != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sh            <= '0;
      cnt           <= '0;
      raw_q         <= '0;
      frac_q        <= '0;
      slot          <= '0;
      slot_full     <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.overrun   <= 1'b0;
      bus.temp_raw  <= '0;
      bus.sign      <= 1'b0;
      bus.bcd_hund  <= '0;
      bus.bcd_tens  <= '0;
      bus.bcd_ones  <= '0;
      bus.bcd_tenth <= '0;
      bus.os_alarm  <= 1'b0;
    end else begin
      bus.out_valid <= 1'b0;
      bus.overrun   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.data_valid) begin
            raw_q  <= next_raw;
            sh     <= {12'd0, mag[10:3]};
            frac_q <= mag[2:0];
            cnt    <= 3'd0;
          end
        end
        CONV: begin
          sh  <= dabble(sh);
          cnt <= cnt + 3'd1;
          if (bus.data_valid) begin
            slot        <= bus.data_in[15:5];
            slot_full   <= 1'b1;
            bus.overrun <= slot_full;
          end
        end
        DONE: begin
          bus.out_valid <= 1'b1;
          bus.temp_raw  <= raw_q;
          bus.sign      <= raw_q[10];
          bus.bcd_hund  <= sh[19:16];
          bus.bcd_tens  <= sh[15:12];
          bus.bcd_ones  <= sh[11:8];
          bus.bcd_tenth <= tenth_of(frac_q);
          if (raw_s >= OS_RAW)     bus.os_alarm <= 1'b1;
          else if (raw_s < HY_RAW) bus.os_alarm <= 1'b0;
          // a word arriving now supersedes a waiting one
          if (have_next) begin
            raw_q       <= next_raw;
            sh          <= {12'd0, mag[10:3]};
            frac_q      <= mag[2:0];
            cnt         <= 3'd0;
            slot_full   <= 1'b0;
            bus.overrun <= slot_full & bus.data_valid;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_lm75a_temp_decoder.sv
// Bench for lm75a_temp_decoder: arithmetic reference model plus directed vectors.
module tb_lm75a_temp_decoder;
  logic clk = 1'b0;
  logic rst = 1'b0;
  lm75a_temp_decoder_if bus();

  lm75a_temp_decoder dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  int          cyc = 0;
  int          done_at = 0;
  bit          m_busy, m_ov, m_ovr, m_sign, m_alarm, pend;
  logic [10:0] m_raw;
  int          m_h, m_t, m_o, m_f;
  logic [15:0] cur_w, pend_w;

  function automatic void publish(input logic [15:0] w);
    logic signed [10:0] r;
    int t, mag;
    r = w[15:5];
    t = int'(r);
    mag = (t < 0) ? -t : t;
    m_raw  = w[15:5];
    m_sign = (t < 0);
    m_h = (mag / 8) / 100;
    m_t = ((mag / 8) / 10) % 10;
    m_o = (mag / 8) % 10;
    m_f = ((mag % 8) * 10) / 8;
    if (t >= 80 * 8)      m_alarm = 1'b1;
    else if (t < 75 * 8)  m_alarm = 1'b0;
  endfunction

  always @(posedge clk) begin
    cyc++;
    m_ov = 1'b0;
    m_ovr = 1'b0;
    if (!rst) begin
      m_busy = 0; pend = 0; m_raw = '0; m_sign = 0;
      m_h = 0; m_t = 0; m_o = 0; m_f = 0; m_alarm = 0;
    end else if (m_busy && cyc == done_at) begin
      publish(cur_w);
      m_ov = 1'b1;
      if (pend || bus.data_valid) begin
        m_ovr = pend && bus.data_valid;
        cur_w = bus.data_valid ? bus.data_in : pend_w;
        pend = 0;
        done_at = cyc + 9;
      end else begin
        m_busy = 0;
      end
    end else if (m_busy) begin
      if (bus.data_valid) begin
        m_ovr = pend;
        pend = 1;
        pend_w = bus.data_in;
      end
    end else if (bus.data_valid) begin
      m_busy = 1;
      cur_w = bus.data_in;
      done_at = cyc + 9;
    end
  end

  function automatic logic [31:0] dut_vec();
    return {bus.busy, bus.out_valid, bus.overrun, bus.temp_raw, bus.sign,
            bus.bcd_hund, bus.bcd_tens, bus.bcd_ones, bus.bcd_tenth,
            bus.os_alarm};
  endfunction

  always @(negedge clk) begin
    logic [31:0] got, exp;
    got = dut_vec();
    exp = rst ? {m_busy, m_ov, m_ovr, m_raw, m_sign, 4'(m_h), 4'(m_t),
                 4'(m_o), 4'(m_f), m_alarm} : 32'h0;
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL cycle_check t=%0t got=%h exp=%h", $time, got, exp);
    end
  end

  task automatic pin(input logic [15:0] w, input logic [15:0] dig,
                     input bit s, input bit al);
    int n;
    @(posedge clk);
    #1 bus.data_valid = 1'b1;
    bus.data_in = w;
    @(posedge clk);
    #1 bus.data_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.out_valid && n < 30);
    n_cmp++;
    if (n != 10) begin
      n_bad++;
      $display("FAIL latency w=%h got=%0d exp=10", w, n);
    end
    n_cmp++;
    if ({4'(m_h), 4'(m_t), 4'(m_o), 4'(m_f)} !== dig || m_sign !== s ||
        m_alarm !== al || m_raw !== w[15:5]) begin
      n_bad++;
      $display("FAIL model_pin w=%h got=%h/%b/%b exp=%h/%b/%b", w,
               {4'(m_h), 4'(m_t), 4'(m_o), 4'(m_f)}, m_sign, m_alarm, dig, s, al);
    end
    n_cmp++;
    if ({bus.sign, bus.bcd_hund, bus.bcd_tens, bus.bcd_ones, bus.bcd_tenth,
         bus.os_alarm, bus.temp_raw} !== {s, dig, al, w[15:5]}) begin
      n_bad++;
      $display("FAIL dut_pin w=%h got=%b/%h/%b exp=%b/%h/%b", w, bus.sign,
               {bus.bcd_hund, bus.bcd_tens, bus.bcd_ones, bus.bcd_tenth},
               bus.os_alarm, s, dig, al);
    end
  endtask

  initial begin
    int nov, novr, first, second;
    logic [10:0] r1, r2;
    bus.data_valid = 1'b0;
    bus.data_in = 16'h0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (dut_vec() !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_state got=%h exp=0", dut_vec());
    end
    rst = 1'b1;
    repeat (2) @(posedge clk);

    pin(16'h1900, 16'h0250, 1'b0, 1'b0);
    pin(16'h1960, 16'h0253, 1'b0, 1'b0);
    pin(16'h19E0, 16'h0258, 1'b0, 1'b0);
    pin(16'hE700, 16'h0250, 1'b1, 1'b0);
    pin(16'h8000, 16'h1280, 1'b1, 1'b0);
    pin(16'hFFE0, 16'h0001, 1'b1, 1'b0);
    pin(16'h0020, 16'h0001, 1'b0, 1'b0);
    pin(16'h7D00, 16'h1250, 1'b0, 1'b1);
    pin(16'h4A00, 16'h0740, 1'b0, 1'b0);
    pin(16'h5000, 16'h0800, 1'b0, 1'b1);
    pin(16'h4C00, 16'h0760, 1'b0, 1'b1);
    pin(16'h4A00, 16'h0740, 1'b0, 1'b0);
    pin(16'h4C00, 16'h0760, 1'b0, 1'b0);

    // three strobes one cycle apart: middle word is lost
    @(posedge clk);
    #1 bus.data_valid = 1'b1;
    bus.data_in = 16'h1900;
    @(posedge clk);
    #1 bus.data_in = 16'h3200;
    @(posedge clk);
    #1 bus.data_in = 16'h4B00;
    @(posedge clk);
    #1 bus.data_valid = 1'b0;
    nov = 0; novr = 0; first = 0; second = 0; r1 = '0; r2 = '0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.overrun) novr++;
      if (bus.out_valid) begin
        nov++;
        if (nov == 1) begin first = i; r1 = bus.temp_raw; end
        if (nov == 2) begin second = i; r2 = bus.temp_raw; end
      end
    end
    n_cmp++;
    if (nov != 2 || novr != 1) begin
      n_bad++;
      $display("FAIL burst_counts got=%0d/%0d exp=2/1", nov, novr);
    end
    n_cmp++;
    if (second - first != 9 || r1 !== 11'd200 || r2 !== 11'd600) begin
      n_bad++;
      $display("FAIL burst_results got=%0d/%0d/%0d exp=9/200/600",
               second - first, r1, r2);
    end

    // reset four cycles into a conversion
    @(posedge clk);
    #1 bus.data_valid = 1'b1;
    bus.data_in = 16'h1900;
    @(posedge clk);
    #1 bus.data_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    n_cmp++;
    if (dut_vec() !== 32'h0) begin
      n_bad++;
      $display("FAIL mid_reset got=%h exp=0", dut_vec());
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    nov = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (bus.out_valid) nov++;
    end
    n_cmp++;
    if (nov != 0) begin
      n_bad++;
      $display("FAIL aborted_word got=%0d exp=0", nov);
    end
    pin(16'h3200, 16'h0500, 1'b0, 1'b0);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
